dsp_pipe_reg_multi: RTL and testbench

- Parametrised multi-stage pipeline register for DSP48A1-style datapaths (A/B/C/D/M/P register slots).
- Generalises the single optional register to 0..4 stages, adding per-stage valid tracking, synchronous clear and an occupancy count.
- Sits between operand muxes and the pre-adder, multiplier and post-adder, so one block covers every xREG setting.

---
 rtl/dsp_pipe_reg_multi.sv | 134 +++++++++++++
 tb/tb_dsp_pipe_reg_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_reg_multi.sv
// dsp_pipe_reg_multi: 0..4 stage pipeline register for DSP48A1-style
// operand/product slots (A/B/C/D/M/P). Each stage carries data plus a
// valid bit. A registered counter tracks how many stages hold valid data.
//
// Optional build macro: PIPE_OUT_HOLD_EN
//   When defined, out comes from an extra register. That register only
//   loads on enabled edges where a valid word lands in the last stage, so
//   out keeps showing the last valid result while bubbles drain.
//   out_vld still follows the last stage's valid bit.
//   When not defined, out is the raw last stage, so bubble data is visible.
//   The macro has no effect when DEPTH = 0.
module dsp_pipe_reg_multi #(
    parameter int                    DATA_WIDTH = 18,
    parameter int                    DEPTH      = 1,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
    localparam int                   CW         = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  rst_a,
    input  logic                  C_ENABLE,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  in_vld,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_vld,
    output logic [CW-1:0]         fill_cnt,
    output logic                  busy
);

    if (DEPTH == 0) begin : g_bypass
        // With no register slot, the block is a plain wire. Clock, enable,
        // clear and reset do not affect the data path.
        assign out      = in;
        assign out_vld  = in_vld;
        assign fill_cnt = '0;
        assign busy     = 1'b0;

        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, CLK, rst_a, C_ENABLE, sclr};
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] stage_q [DEPTH];
        logic [DATA_WIDTH-1:0] stage_d [DEPTH];
        logic [DEPTH-1:0]      vld_q;
        logic [DEPTH-1:0]      vld_d;
        logic [CW-1:0]         fill_cnt_q;
        logic [CW-1:0]         fill_cnt_d;

        // Next-state logic. Priority is sclr, then C_ENABLE (shift), then hold.
        always_comb begin
            // NOTE: every output of this block gets a default first. That way
            // no path leaves a value unassigned, and no latch is inferred.
            stage_d    = stage_q;
            vld_d      = vld_q;
            fill_cnt_d = fill_cnt_q;
            if (sclr) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage_d[k] = RST_VAL;
                end
                vld_d      = '0;
                fill_cnt_d = '0;
            end else if (C_ENABLE) begin
                // Data moves on every enabled edge. The valid bit only
                // qualifies it.
                stage_d[0] = in;
                vld_d[0]   = in_vld;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_d[k] = stage_q[k-1];
                    vld_d[k]   = vld_q[k-1];
                end
                // A valid word entering while none leaves grows the count.
                // A word leaving while none enters shrinks it.
                if (in_vld && !vld_q[DEPTH-1]) begin
                    fill_cnt_d = fill_cnt_q + CW'(1);
                end else if (!in_vld && vld_q[DEPTH-1]) begin
                    fill_cnt_d = fill_cnt_q - CW'(1);
                end
            end
        end

        // Stage registers with asynchronous reset.
        always_ff @(posedge CLK or posedge rst_a) begin
            if (rst_a) begin
                // NOTE: the stage array is built from real flops, not RAM.
                // Every stage must show RST_VAL right after reset, so each
                // one is reset explicitly.
                for (int k = 0; k < DEPTH; k++) begin
                    stage_q[k] <= RST_VAL;
                end
                vld_q      <= '0;
                fill_cnt_q <= '0;
            end else begin
                // NOTE: non-blocking assignments let every stage sample the
                // pre-edge value of its neighbour. That is what makes the
                // chain shift instead of collapsing.
                stage_q    <= stage_d;
                vld_q      <= vld_d;
                fill_cnt_q <= fill_cnt_d;
            end
        end

`ifdef PIPE_OUT_HOLD_EN
        logic [DATA_WIDTH-1:0] hold_q;
        logic [DATA_WIDTH-1:0] hold_d;

        // The hold register loads alongside the last stage, but only when
        // the word landing there is valid.
        always_comb begin
            hold_d = hold_q;
            if (sclr) begin
                hold_d = RST_VAL;
            end else if (C_ENABLE && vld_d[DEPTH-1]) begin
                hold_d = stage_d[DEPTH-1];
            end
        end

        // Hold register, reset to RST_VAL like the stages.
        always_ff @(posedge CLK or posedge rst_a) begin
            if (rst_a) begin
                hold_q <= RST_VAL;
            end else begin
                hold_q <= hold_d;
            end
        end

        assign out = hold_q;
`else
        assign out = stage_q[DEPTH-1];
`endif
        assign out_vld  = vld_q[DEPTH-1];
        assign fill_cnt = fill_cnt_q;
        assign busy     = (fill_cnt_q != '0);
    end

endmodule

// File: tb/tb_dsp_pipe_reg_multi.sv
// Self-checking bench for dsp_pipe_reg_multi. DEPTH = 0..4 instances share
// one input stream. The reference model keeps the history of words
// accepted since the last reset or clear. Each depth's expected output is
// simply the word accepted DEPTH enabled edges ago.
module tb_dsp_pipe_reg_multi;

    localparam int          DW = 18;
    localparam logic [17:0] RV = 18'h15A5A;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          v;
    } ent_t;

    logic          CLK = 1'b0;
    logic          rst_a;
    logic          C_ENABLE;
    logic          sclr;
    logic [DW-1:0] in_d;
    logic          in_vld;

    logic [DW-1:0] out0, out1, out2, out3, out4;
    logic          ov0, ov1, ov2, ov3, ov4;
    logic [0:0]    fc0, fc1;
    logic [1:0]    fc2, fc3;
    logic [2:0]    fc4;
    logic          bz0, bz1, bz2, bz3, bz4;

    int   total = 0;
    int   bad   = 0;
    ent_t hist[$];

    always #5 CLK = ~CLK;

    dsp_pipe_reg_multi #(.DATA_WIDTH(DW), .DEPTH(0), .RST_VAL(RV)) u_d0 (
        .CLK(CLK), .rst_a(rst_a), .C_ENABLE(C_ENABLE), .sclr(sclr), .in(in_d),
        .in_vld(in_vld), .out(out0), .out_vld(ov0), .fill_cnt(fc0), .busy(bz0));
    dsp_pipe_reg_multi #(.DATA_WIDTH(DW), .DEPTH(1), .RST_VAL(RV)) u_d1 (
        .CLK(CLK), .rst_a(rst_a), .C_ENABLE(C_ENABLE), .sclr(sclr), .in(in_d),
        .in_vld(in_vld), .out(out1), .out_vld(ov1), .fill_cnt(fc1), .busy(bz1));
    dsp_pipe_reg_multi #(.DATA_WIDTH(DW), .DEPTH(2), .RST_VAL(RV)) u_d2 (
        .CLK(CLK), .rst_a(rst_a), .C_ENABLE(C_ENABLE), .sclr(sclr), .in(in_d),
        .in_vld(in_vld), .out(out2), .out_vld(ov2), .fill_cnt(fc2), .busy(bz2));
    dsp_pipe_reg_multi #(.DATA_WIDTH(DW), .DEPTH(3), .RST_VAL(RV)) u_d3 (
        .CLK(CLK), .rst_a(rst_a), .C_ENABLE(C_ENABLE), .sclr(sclr), .in(in_d),
        .in_vld(in_vld), .out(out3), .out_vld(ov3), .fill_cnt(fc3), .busy(bz3));
    dsp_pipe_reg_multi #(.DATA_WIDTH(DW), .DEPTH(4), .RST_VAL(RV)) u_d4 (
        .CLK(CLK), .rst_a(rst_a), .C_ENABLE(C_ENABLE), .sclr(sclr), .in(in_d),
        .in_vld(in_vld), .out(out4), .out_vld(ov4), .fill_cnt(fc4), .busy(bz4));

    // ---------------- reference model ----------------
    // Word at the output of a depth-d pipe: the entry accepted d enabled
    // edges ago, or the reset word if fewer than d edges have been seen.
    function automatic ent_t exp_stage(input int d);
        ent_t r;
        r = '{d: RV, v: 1'b0};
        if (hist.size() >= d) r = hist[hist.size() - d];
        return r;
    endfunction

    // Number of valid words among the last d accepted entries.
    function automatic int exp_fill(input int d);
        int n = 0;
        for (int i = 1; i <= d; i++) begin
            if (hist.size() >= i && hist[hist.size() - i].v) n++;
        end
        return n;
    endfunction

    // Most recent valid word that has reached the output of a depth-d pipe.
    function automatic logic [DW-1:0] exp_hold(input int d);
        for (int i = hist.size() - d; i >= 0; i--) begin
            if (hist[i].v) return hist[i].d;
        end
        return RV;
    endfunction

    function automatic logic [DW-1:0] get_out(input int d);
        case (d)
            1:       return out1;
            2:       return out2;
            3:       return out3;
            default: return out4;
        endcase
    endfunction

    function automatic logic get_vld(input int d);
        case (d)
            1:       return ov1;
            2:       return ov2;
            3:       return ov3;
            default: return ov4;
        endcase
    endfunction

    function automatic logic [31:0] get_fill(input int d);
        case (d)
            1:       return {31'd0, fc1};
            2:       return {30'd0, fc2};
            3:       return {30'd0, fc3};
            default: return {29'd0, fc4};
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            1:       return bz1;
            2:       return bz2;
            3:       return bz3;
            default: return bz4;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        ent_t          e;
        logic [DW-1:0] eo;
        chk({tag, " d0 out"},  {14'd0, out0}, {14'd0, in_d});
        chk({tag, " d0 vld"},  {31'd0, ov0},  {31'd0, in_vld});
        chk({tag, " d0 fill"}, {31'd0, fc0},  32'd0);
        chk({tag, " d0 busy"}, {31'd0, bz0},  32'd0);
        for (int d = 1; d <= 4; d++) begin
            e = exp_stage(d);
`ifdef PIPE_OUT_HOLD_EN
            eo = exp_hold(d);
`else
            eo = e.d;
`endif
            chk($sformatf("%s d%0d out", tag, d),  {14'd0, get_out(d)},  {14'd0, eo});
            chk($sformatf("%s d%0d vld", tag, d),  {31'd0, get_vld(d)},  {31'd0, e.v});
            chk($sformatf("%s d%0d fill", tag, d), get_fill(d),          exp_fill(d));
            chk($sformatf("%s d%0d busy", tag, d), {31'd0, get_busy(d)}, {31'd0, exp_fill(d) != 0});
        end
    endtask

    // One clock: drive inputs while CLK is low, let the model see the
    // rising edge, then check on the falling edge.
    task automatic cycle(input string tag, input logic [DW-1:0] din, input logic v,
                         input logic en, input logic clr);
        in_d     = din;
        in_vld   = v;
        C_ENABLE = en;
        sclr     = clr;
        @(posedge CLK);
        if (!rst_a) begin
            if (clr)     hist.delete();
            else if (en) hist.push_back('{d: din, v: v});
        end
        @(negedge CLK);
        check_all(tag);
    endtask

    // Assert rst_a between edges, check outputs before any edge, then release.
    task automatic async_reset(input string tag);
        #2;
        rst_a = 1'b1;
        hist.delete();
        #1;
        check_all(tag);
        #1;
        rst_a = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_a    = 1'b1;
        C_ENABLE = 1'b0;
        sclr     = 1'b0;
        in_vld   = 1'b0;
        in_d     = '0;
        hist.delete();
        #2;
        check_all("reset");
        // Under reset the DEPTH=0 pipe still follows its input.
        in_d   = 18'h3FFFF;
        in_vld = 1'b1;
        #1;
        check_all("reset_bypass");
        @(negedge CLK);
        rst_a = 1'b0;

        // Three back-to-back valid words, then drain.
        cycle("burst", 18'h00011, 1'b1, 1'b1, 1'b0);
        cycle("burst", 18'h00022, 1'b1, 1'b1, 1'b0);
        cycle("burst", 18'h00033, 1'b1, 1'b1, 1'b0);
        repeat (5) cycle("drain", 18'h3FFFF, 1'b0, 1'b1, 1'b0);

        // Fill three stages, stall for five cycles, then resume.
        cycle("load", 18'h00044, 1'b1, 1'b1, 1'b0);
        cycle("load", 18'h00055, 1'b1, 1'b1, 1'b0);
        cycle("load", 18'h00066, 1'b1, 1'b1, 1'b0);
        repeat (5) cycle("stall", DW'($urandom), 1'($urandom), 1'b0, 1'b0);
        repeat (5) cycle("resume", 18'h00000, 1'b0, 1'b1, 1'b0);

        // Synchronous clear while stalled with a full pipe.
        repeat (4) cycle("fill", DW'($urandom), 1'b1, 1'b1, 1'b0);
        cycle("sclr_noen", 18'h12345, 1'b1, 1'b0, 1'b1);
        cycle("after_sclr", 18'h12345, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while two valid words are in flight.
        cycle("inflight", 18'h000A1, 1'b1, 1'b1, 1'b0);
        cycle("inflight", 18'h000A2, 1'b1, 1'b1, 1'b0);
        async_reset("async_rst");
        cycle("post_rst", 18'h2BEEF, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle("post_rst", DW'($urandom), 1'b0, 1'b1, 1'b0);

        // One valid word followed by bubbles that carry junk data.
        cycle("hold", 18'h00AAA, 1'b1, 1'b1, 1'b0);
        repeat (5) cycle("bubble", DW'($urandom), 1'b0, 1'b1, 1'b0);

        // Randomized traffic with occasional clear and reset.
        for (int n = 0; n < 400; n++) begin
            if (n % 137 == 136) async_reset("rand_rst");
            cycle("rand", DW'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 24) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
